mem_wb_elastic_reg: RTL and testbench
=====================================

// Module: mem_wb_elastic_reg
// PURPOSE
//  Parametrised MEM/WB pipeline register with a valid/ready handshake.
//  Sits between the data-memory stage and register-file write-back.
//  Adds stall back-pressure, flush and bubble tracking.
//  Optional skid buffer (SKID=1) gives full throughput with a registered in_ready.
//  RegWrite is suppressed for bubbles and, optionally, for register 0.
// PARAMETERS
//  DATA_W      32  width of ALUresult/readData/wbData
//  REG_ADDR_W  5   width of writeReg
//  SKID        1   0: one entry, combinational in_ready; 1: two entries, registered in_ready
//  ZERO_GUARD  1   1: writes to register 0 force RegWriteOut=0
// PORTS
//  clk         in   1           rising-edge clock
//  rst         in   1           synchronous reset, active-high
//  flush       in   1           synchronous discard of all held entries
//  in_valid    in   1           MEM stage presents an instruction
//  in_ready    out  1           register can accept this cycle
//  RegWrite    in   1           register-file write enable from MEM
//  MemtoReg    in   1           1: write back readData; 0: write back ALUresult
//  ALUresult   in   DATA_W      ALU result from MEM
//  readData    in   DATA_W      data-memory read data
//  writeReg    in   REG_ADDR_W  destination register
//  out_valid   out  1           WB entry valid
//  out_ready   in   1           WB consumes the entry this cycle
//  RegWriteOut out  1           gated write enable, see BEHAVIOUR
//  MemtoRegOut out  1           held MemtoReg
//  ALUresultOut out DATA_W      held ALUresult
//  readDataOut out  DATA_W      held readData
//  writeRegOut out  REG_ADDR_W  held writeReg
//  wbDataOut   out  DATA_W      MemtoRegOut ? readDataOut : ALUresultOut
// BEHAVIOUR
//  Transfers
//  - Accept when in_valid & in_ready at a rising edge.
//  - Consume when out_valid & out_ready at a rising edge.
//  - Latency is 1 cycle: an accepted entry appears on the outputs at the next edge.
//  Reset (rst=1 at an edge)
//  - State goes to EMPTY.
//  - out_valid=0 and all data/control outputs are 0.
//  - in_ready=0 while rst is high.
//  Flush (rst=0, flush=1)
//  - State goes to EMPTY and out_valid=0; held data is don't-care.
//  - Any simultaneous input is dropped.
//  - No consume is counted.
//  - Priority: rst > flush > normal operation.
//  States (SKID=1): EMPTY, ONE (main holds the output), TWO (main + skid)
//  - EMPTY: accept -> ONE.
//  - ONE:
//    - accept & consume -> ONE (main loads new entry).
//    - accept only -> TWO (new entry goes to skid).
//    - consume only -> EMPTY.
//  - TWO: consume -> ONE (skid moves to main); no accept is possible.
//  - in_ready = !rst & (state != TWO), driven from a flop.
//  SKID=0
//  - Single entry.
//  - in_ready = !rst & (!out_valid | out_ready), combinational.
//  - Accept with consume in the same cycle replaces the entry.
//  Output rules
//  - Outputs hold stable while out_valid & !out_ready.
//  - Entries leave in FIFO order and none is lost or duplicated.
//  - RegWriteOut = out_valid & heldRegWrite & !(ZERO_GUARD & writeRegOut==0).
//  - wbDataOut is a combinational mux of the held fields; no arithmetic and no truncation.
// TESTING
//  1 Reset: rst high 2 cycles -> out_valid=0, RegWriteOut=0, all outputs 0, in_ready=0; then in_ready=1.
//  2 Streaming: out_ready=1, 8 back-to-back entries (ALUresult=i, writeReg=i+1)
//    -> each appears 1 cycle later, in_ready stays 1.
//  3 Stall, SKID=1: out_ready=0 with entries A,B sent -> B lands in skid, in_ready=0 next cycle,
//    outputs hold A; release -> A then B on successive cycles.
//  4 Flush: flush in the TWO state together with in_valid=1 -> next cycle out_valid=0,
//    in_ready=1, and the flushed/dropped entries never appear.
//  5 Gating: RegWrite=1, writeReg=0, ZERO_GUARD=1 -> RegWriteOut=0.
//    Same with writeReg=5 -> RegWriteOut=1.
//  6 Mux: MemtoReg=1, readData=32'hDEADBEEF, ALUresult=32'h1234 -> wbDataOut=32'hDEADBEEF.
//    MemtoReg=0 -> wbDataOut=32'h1234.

Source files
------------

// File: rtl/mem_wb_elastic_reg_if.sv
// MEM/WB handshake bundle: MEM-side producer fields plus WB-side consumer fields.
interface mem_wb_elastic_reg_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  // MEM stage -> register
  logic                  in_valid;
  logic                  in_ready;
  logic                  RegWrite;
  logic                  MemtoReg;
  logic [DATA_W-1:0]     ALUresult;
  logic [DATA_W-1:0]     readData;
  logic [REG_ADDR_W-1:0] writeReg;

  // register -> WB stage
  logic                  out_valid;
  logic                  out_ready;
  logic                  RegWriteOut;
  logic                  MemtoRegOut;
  logic [DATA_W-1:0]     ALUresultOut;
  logic [DATA_W-1:0]     readDataOut;
  logic [REG_ADDR_W-1:0] writeRegOut;
  logic [DATA_W-1:0]     wbDataOut;

  // The pipeline register itself
  modport slave (
    input  in_valid, RegWrite, MemtoReg, ALUresult, readData, writeReg, out_ready,
    output in_ready, out_valid, RegWriteOut, MemtoRegOut, ALUresultOut,
           readDataOut, writeRegOut, wbDataOut
  );

  // The surrounding pipeline (MEM producer and WB consumer)
  modport master (
    output in_valid, RegWrite, MemtoReg, ALUresult, readData, writeReg, out_ready,
    input  in_ready, out_valid, RegWriteOut, MemtoRegOut, ALUresultOut,
           readDataOut, writeRegOut, wbDataOut
  );
endinterface

// File: rtl/mem_wb_elastic_reg.sv
// MEM/WB elastic pipeline register with valid/ready handshake, flush,
// optional two-entry skid buffer and register-0 write suppression.
module mem_wb_elastic_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit SKID       = 1'b1,
  parameter bit ZERO_GUARD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  mem_wb_elastic_reg_if.slave   bus
);

  typedef struct packed {
    logic                  regwrite;
    logic                  memtoreg;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     rdata;
    logic [REG_ADDR_W-1:0] wreg;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t r_state;
  logic   r_vld_p1;
  logic   r_in_ready;
  entry_t r_main_p1;
  entry_t r_skid_p1;

  entry_t w_in_entry;
  logic   w_in_ready;
  logic   w_acc;
  logic   w_con;
  logic   w_zero_dst;

  assign w_in_entry = '{regwrite: bus.RegWrite,
                        memtoreg: bus.MemtoReg,
                        alu:      bus.ALUresult,
                        rdata:    bus.readData,
                        wreg:     bus.writeReg};

  // With the skid entry, ready comes straight from a flop so the MEM stage
  // sees no combinational path from out_ready; without it, ready must look
  // through to the consumer to keep single-entry throughput.
  assign w_in_ready = SKID ? (!rst & r_in_ready)
                           : (!rst & (!r_vld_p1 | bus.out_ready));

  assign w_acc = bus.in_valid & w_in_ready;
  assign w_con = r_vld_p1 & bus.out_ready;

  // Occupancy FSM: main entry drives the outputs, skid catches the one
  // extra entry accepted while WB stalls; flush discards both.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_vld_p1   <= 1'b0;
      r_in_ready <= 1'b1;
      r_main_p1  <= '0;
      r_skid_p1  <= '0;
    end else if (flush) begin
      r_state    <= S_EMPTY;
      r_vld_p1   <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            r_main_p1 <= w_in_entry;
            r_state   <= S_ONE;
            r_vld_p1  <= 1'b1;
          end
        end
        S_ONE: begin
          if (w_acc && w_con) begin
            r_main_p1 <= w_in_entry;
          end else if (w_acc) begin
            // only reachable with SKID=1: WB stalled, park the newcomer
            r_skid_p1  <= w_in_entry;
            r_state    <= S_TWO;
            r_in_ready <= 1'b0;
          end else if (w_con) begin
            r_state  <= S_EMPTY;
            r_vld_p1 <= 1'b0;
          end
        end
        S_TWO: begin
          if (w_con) begin
            r_main_p1  <= r_skid_p1;
            r_state    <= S_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_EMPTY;
          r_vld_p1   <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Write-back view: gated write enable and the data mux over held fields
  assign w_zero_dst      = ZERO_GUARD & (r_main_p1.wreg == '0);
  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_vld_p1;
  assign bus.RegWriteOut = r_vld_p1 & r_main_p1.regwrite & !w_zero_dst;
  assign bus.MemtoRegOut = r_main_p1.memtoreg;
  assign bus.ALUresultOut = r_main_p1.alu;
  assign bus.readDataOut = r_main_p1.rdata;
  assign bus.writeRegOut = r_main_p1.wreg;
  assign bus.wbDataOut   = r_main_p1.memtoreg ? r_main_p1.rdata : r_main_p1.alu;

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// Directed bench for mem_wb_elastic_reg (DATA_W=32, REG_ADDR_W=5, SKID=1, ZERO_GUARD=1).
module tb_mem_wb_elastic_reg;

  logic clk;
  logic rst;
  logic flush;
  int   tests;
  int   fails;

  mem_wb_elastic_reg_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  mem_wb_elastic_reg #(
    .DATA_W(32), .REG_ADDR_W(5), .SKID(1'b1), .ZERO_GUARD(1'b1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] rd, input logic [4:0] wr);
    bus.in_valid  = v;
    bus.RegWrite  = rw;
    bus.MemtoReg  = m2r;
    bus.ALUresult = alu;
    bus.readData  = rd;
    bus.writeReg  = wr;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

    // ---- 1 reset: two cycles high
    tick();
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_regwrite", 64'(bus.RegWriteOut), 64'h0);
    check("rst_memtoreg", 64'(bus.MemtoRegOut), 64'h0);
    check("rst_alu", 64'(bus.ALUresultOut), 64'h0);
    check("rst_rdata", 64'(bus.readDataOut), 64'h0);
    check("rst_wreg", 64'(bus.writeRegOut), 64'h0);
    check("rst_wbdata", 64'(bus.wbDataOut), 64'h0);
    check("rst_in_ready", 64'(bus.in_ready), 64'h0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'h1);

    // ---- 2 streaming with out_ready=1
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(i), 32'h0, 5'(i + 1));
      check($sformatf("stream_in_ready_%0d", i), 64'(bus.in_ready), 64'h1);
      tick();
      check($sformatf("stream_valid_%0d", i), 64'(bus.out_valid), 64'h1);
      check($sformatf("stream_alu_%0d", i), 64'(bus.ALUresultOut), 64'(i));
      check($sformatf("stream_wreg_%0d", i), 64'(bus.writeRegOut), 64'(i + 1));
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    check("stream_drain_valid", 64'(bus.out_valid), 64'h0);

    // ---- 3 stall with skid: A then B while WB stalled
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'hA0, 32'h0, 5'd3);
    tick();
    check("stall_A_valid", 64'(bus.out_valid), 64'h1);
    check("stall_A_alu", 64'(bus.ALUresultOut), 64'hA0);
    check("stall_ONE_in_ready", 64'(bus.in_ready), 64'h1);
    drive(1'b1, 1'b1, 1'b0, 32'hB0, 32'h0, 5'd4);
    tick();
    check("stall_TWO_in_ready", 64'(bus.in_ready), 64'h0);
    check("stall_hold_A_alu", 64'(bus.ALUresultOut), 64'hA0);
    check("stall_hold_A_wreg", 64'(bus.writeRegOut), 64'd3);
    drive(1'b1, 1'b1, 1'b0, 32'hC0, 32'h0, 5'd6);  // must be refused
    tick();
    check("stall_still_A_alu", 64'(bus.ALUresultOut), 64'hA0);
    check("stall_still_valid", 64'(bus.out_valid), 64'h1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    bus.out_ready = 1'b1;
    tick();
    check("release_B_alu", 64'(bus.ALUresultOut), 64'hB0);
    check("release_B_wreg", 64'(bus.writeRegOut), 64'd4);
    check("release_in_ready", 64'(bus.in_ready), 64'h1);
    tick();
    check("release_empty", 64'(bus.out_valid), 64'h0);

    // ---- 4 flush in TWO with in_valid=1
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'hD0, 32'h0, 5'd7);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'hE0, 32'h0, 5'd8);
    tick();
    check("pre_flush_in_ready", 64'(bus.in_ready), 64'h0);
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'hF0, 32'h0, 5'd9);
    tick();
    check("flush_TWO_valid", 64'(bus.out_valid), 64'h0);
    check("flush_TWO_in_ready", 64'(bus.in_ready), 64'h1);
    check("flush_TWO_regwrite", 64'(bus.RegWriteOut), 64'h0);
    // flush in ONE while an accept is offered: the offered entry is dropped
    flush = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h60, 32'h0, 5'd10);
    tick();
    check("flush_ONE_pre_alu", 64'(bus.ALUresultOut), 64'h60);
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h70, 32'h0, 5'd11);
    tick();
    check("flush_ONE_valid", 64'(bus.out_valid), 64'h0);
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    bus.out_ready = 1'b1;
    tick();
    check("flush_nothing_left", 64'(bus.out_valid), 64'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h99, 32'h0, 5'd12);
    tick();
    check("after_flush_alu", 64'(bus.ALUresultOut), 64'h99);
    check("after_flush_wreg", 64'(bus.writeRegOut), 64'd12);

    // ---- 5 write-enable gating
    drive(1'b1, 1'b1, 1'b0, 32'h11, 32'h0, 5'd0);
    tick();
    check("gate_r0_valid", 64'(bus.out_valid), 64'h1);
    check("gate_r0_regwrite", 64'(bus.RegWriteOut), 64'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h22, 32'h0, 5'd5);
    tick();
    check("gate_r5_regwrite", 64'(bus.RegWriteOut), 64'h1);
    drive(1'b1, 1'b0, 1'b0, 32'h33, 32'h0, 5'd5);
    tick();
    check("gate_rw0_regwrite", 64'(bus.RegWriteOut), 64'h0);

    // ---- 6 write-back mux
    drive(1'b1, 1'b1, 1'b1, 32'h1234, 32'hDEADBEEF, 5'd2);
    tick();
    check("mux_mem_wbdata", 64'(bus.wbDataOut), 64'hDEADBEEF);
    check("mux_mem_memtoreg", 64'(bus.MemtoRegOut), 64'h1);
    check("mux_mem_rdata", 64'(bus.readDataOut), 64'hDEADBEEF);
    drive(1'b1, 1'b1, 1'b0, 32'h1234, 32'hDEADBEEF, 5'd2);
    tick();
    check("mux_alu_wbdata", 64'(bus.wbDataOut), 64'h1234);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    check("bubble_valid", 64'(bus.out_valid), 64'h0);
    check("bubble_regwrite", 64'(bus.RegWriteOut), 64'h0);

    // ---- reset while holding an entry
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h55, 32'h66, 5'd9);
    tick();
    check("prereset_valid", 64'(bus.out_valid), 64'h1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    check("midrst_valid", 64'(bus.out_valid), 64'h0);
    check("midrst_wbdata", 64'(bus.wbDataOut), 64'h0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'h0);
    rst = 1'b0;
    #1;
    check("midrst_release_in_ready", 64'(bus.in_ready), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
